// File: rtl/register_file_mp.sv
// Multi-port register file with two prioritised write lanes, optional bypass,
// optional hardwired zero register and a per-register pending scoreboard.
module register_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic [1:0]                   wr_en,
  input  logic [2*ADDR_W-1:0]          wr_addr,
  input  logic [2*DATA_W-1:0]          wr_data,
  input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
  output logic [NUM_READ*DATA_W-1:0]   rd_data,
  output logic [NUM_READ-1:0]          rd_ready,
  input  logic                         alloc_en,
  input  logic [ADDR_W-1:0]            alloc_addr,
  output logic                         pend_any
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);
  localparam logic [DEPTH-1:0] ZMASK = ZR ? {{(DEPTH-1){1'b1}}, 1'b0} : {DEPTH{1'b1}};

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_pend;

  logic [ADDR_W-1:0] w_wa0, w_wa1;
  logic [DATA_W-1:0] w_wd0, w_wd1;
  logic              w_we0, w_we1;
  logic [DEPTH-1:0]  w_clr_mask, w_set_mask, w_pend_nxt;

  assign w_wa0 = wr_addr[0 +: ADDR_W];
  assign w_wa1 = wr_addr[ADDR_W +: ADDR_W];
  assign w_wd0 = wr_data[0 +: DATA_W];
  assign w_wd1 = wr_data[DATA_W +: DATA_W];
  assign w_we0 = wr_en[0] & ~(ZR & (w_wa0 == {ADDR_W{1'b0}}));
  assign w_we1 = wr_en[1] & ~(ZR & (w_wa1 == {ADDR_W{1'b0}}));

  // A same-cycle alloc overrides the writeback clear: the new producer supersedes.
  assign w_clr_mask = ({{(DEPTH-1){1'b0}}, wr_en[0]} << w_wa0)
                    | ({{(DEPTH-1){1'b0}}, wr_en[1]} << w_wa1);
  assign w_set_mask = ({{(DEPTH-1){1'b0}}, alloc_en} << alloc_addr);
  assign w_pend_nxt = ((r_pend & ~w_clr_mask) | w_set_mask) & ZMASK;

  assign pend_any = |r_pend;

  // Register array and scoreboard update; lane 1 is written last so it wins collisions.
  always_ff @(posedge clk) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DATA_W{1'b0}};
      end
      r_pend <= {DEPTH{1'b0}};
    end else begin
      if (w_we0) begin
        r_mem[w_wa0] <= w_wd0;
      end
      if (w_we1) begin
        r_mem[w_wa1] <= w_wd1;
      end
      r_pend <= w_pend_nxt;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_READ; g++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic              w_zero, w_hit0, w_hit1;
      logic [DATA_W-1:0] w_data;
      logic              w_ready;

      assign w_addr = rd_addr[g*ADDR_W +: ADDR_W];
      assign w_zero = ZR & (w_addr == {ADDR_W{1'b0}});
      assign w_hit0 = BP & wr_en[0] & (w_wa0 == w_addr);
      assign w_hit1 = BP & wr_en[1] & (w_wa1 == w_addr);

      // Read mux: zero register, then lane-1/lane-0 forwarding, then stored state.
      always_comb begin
        w_data  = {DATA_W{1'b0}};
        w_ready = 1'b1;
        if (w_zero) begin
          w_data  = {DATA_W{1'b0}};
          w_ready = 1'b1;
        end else if (w_hit1) begin
          w_data  = w_wd1;
          w_ready = 1'b1;
        end else if (w_hit0) begin
          w_data  = w_wd0;
          w_ready = 1'b1;
        end else begin
          w_data  = r_mem[w_addr];
          w_ready = ~r_pend[w_addr];
        end
      end

      assign rd_data[g*DATA_W +: DATA_W] = w_data;
      assign rd_ready[g]                 = w_ready;
    end
  endgenerate

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench: DUT A (4 ports, zero reg, bypass) and DUT B (2 ports, neither)
// share write/alloc stimulus; expectations are queued at drive time and popped at sample time.
module tb_register_file_mp;

  logic         clk = 1'b0;
  logic         clr;
  logic [1:0]   wr_en;
  logic [9:0]   wr_addr;
  logic [63:0]  wr_data;
  logic [19:0]  rd_addr;
  logic         alloc_en;
  logic [4:0]   alloc_addr;
  logic [127:0] rd_data_a;
  logic [3:0]   rd_ready_a;
  logic         pend_a;
  logic [63:0]  rd_data_b;
  logic [1:0]   rd_ready_b;
  logic         pend_b;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          dut;
    int          port;
    logic [32:0] exp;
    string       tag;
  } sb_t;
  sb_t q[$];

  logic [31:0] ma [32];
  logic [31:0] mb [32];
  logic [31:0] pa, pb;

  always #5 clk = ~clk;

  register_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_READ(4), .ZERO_REG(1), .BYPASS(1)) u_a (
    .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_ready(rd_ready_a),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .pend_any(pend_a));

  register_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2), .ZERO_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr[9:0]), .rd_data(rd_data_b), .rd_ready(rd_ready_b),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .pend_any(pend_b));

  // Expected {ready, data} for one read port of a given configuration.
  function automatic logic [32:0] model_rd(input bit zr, input bit by, input logic [4:0] a,
                                           input logic [31:0] mem_v, input logic pend_v);
    if (zr && a == 5'd0) return {1'b1, 32'h0000_0000};
    if (by && wr_en[1] && wr_addr[9:5] == a) return {1'b1, wr_data[63:32]};
    if (by && wr_en[0] && wr_addr[4:0] == a) return {1'b1, wr_data[31:0]};
    return {~pend_v, mem_v};
  endfunction

  function automatic logic [32:0] actual(input int dut, input int port);
    if (dut == 0) begin
      if (port < 0) return {32'h0, pend_a};
      return {rd_ready_a[port], rd_data_a[port*32 +: 32]};
    end
    if (port < 0) return {32'h0, pend_b};
    return {rd_ready_b[port], rd_data_b[port*32 +: 32]};
  endfunction

  task automatic push(input int dut, input int port, input logic [32:0] exp, input string tag);
    sb_t e;
    e.dut = dut; e.port = port; e.exp = exp; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic model_edge();
    logic [4:0] a;
    if (!clr) begin
      for (int i = 0; i < 32; i++) begin ma[i] = 32'h0; mb[i] = 32'h0; end
      pa = 32'h0; pb = 32'h0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (wr_en[l]) begin
          a = wr_addr[l*5 +: 5];
          if (a != 5'd0) ma[a] = wr_data[l*32 +: 32];
          mb[a] = wr_data[l*32 +: 32];
          pa[a] = 1'b0;
          pb[a] = 1'b0;
        end
      end
      if (alloc_en) begin
        if (alloc_addr != 5'd0) pa[alloc_addr] = 1'b1;
        pb[alloc_addr] = 1'b1;
      end
    end
  endtask

  // Queue model expectations, sample, pop and compare, then advance one clock.
  task automatic cycle();
    sb_t         e;
    logic [32:0] act;
    logic [4:0]  a;
    for (int p = 0; p < 4; p++) begin
      a = rd_addr[p*5 +: 5];
      push(0, p, model_rd(1'b1, 1'b1, a, ma[a], pa[a]), $sformatf("a_port%0d", p));
    end
    for (int p = 0; p < 2; p++) begin
      a = rd_addr[p*5 +: 5];
      push(1, p, model_rd(1'b0, 1'b0, a, mb[a], pb[a]), $sformatf("b_port%0d", p));
    end
    push(0, -1, {32'h0, (pa != 32'h0)}, "a_pend_any");
    push(1, -1, {32'h0, (pb != 32'h0)}, "b_pend_any");
    #1;
    while (q.size() > 0) begin
      e   = q.pop_front();
      act = actual(e.dut, e.port);
      n_checks++;
      assert (act === e.exp) else begin
        n_errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, act, e.exp);
      end
    end
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = 2'b00; alloc_en = 1'b0; clr = 1'b1;
  endtask

  task automatic wr(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                    input logic [4:0] a1, input logic [31:0] d1);
    wr_en = en; wr_addr = {a1, a0}; wr_data = {d1, d0};
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                    input logic [4:0] a3);
    rd_addr = {a3, a2, a1, a0};
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin ma[i] = 32'h0; mb[i] = 32'h0; end
    pa = 32'h0; pb = 32'h0;
    clr = 1'b0; wr_en = 2'b00; wr_addr = 10'h0; wr_data = 64'h0;
    rd_addr = 20'h0; alloc_en = 1'b0; alloc_addr = 5'd0;
    @(negedge clk);
    model_edge();
    @(posedge clk);
    @(negedge clk);

    // Reset state
    rd(5'd5, 5'd0, 5'd7, 5'd31);
    push(0, 0, {1'b1, 32'h0}, "reset_r5");
    push(0, -1, 33'h0, "reset_pend");
    cycle();

    // Reset clear drops data and a write issued in the clr cycle
    idle(); wr(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'h0);
    cycle();
    idle();
    push(0, 0, {1'b1, 32'hDEAD_BEEF}, "r5_written");
    cycle();
    clr = 1'b0; wr(2'b01, 5'd6, 32'h1234_5678, 5'd0, 32'h0);
    alloc_en = 1'b1; alloc_addr = 5'd6;
    cycle();
    idle(); rd(5'd5, 5'd6, 5'd5, 5'd6);
    push(0, 0, {1'b1, 32'h0}, "r5_after_clr");
    push(0, 1, {1'b1, 32'h0}, "clr_cycle_write_dropped");
    push(1, -1, 33'h0, "pend_after_clr");
    cycle();

    // Dual-lane collision on r7, lane 1 wins
    wr(2'b11, 5'd7, 32'h1111_1111, 5'd7, 32'h2222_2222); rd(5'd7, 5'd7, 5'd7, 5'd7);
    push(0, 0, {1'b1, 32'h2222_2222}, "collision_bypass");
    cycle();
    idle();
    for (int p = 0; p < 4; p++) push(0, p, {1'b1, 32'h2222_2222}, "collision_r7");
    push(1, 1, {1'b1, 32'h2222_2222}, "collision_r7_b");
    cycle();
    wr(2'b11, 5'd3, 32'h0000_0033, 5'd4, 32'h0000_0044);
    cycle();
    idle(); rd(5'd3, 5'd4, 5'd3, 5'd4);
    push(1, 0, {1'b1, 32'h0000_0033}, "distinct_r3");
    push(1, 1, {1'b1, 32'h0000_0044}, "distinct_r4");
    cycle();

    // Zero register
    wr(2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0); alloc_en = 1'b1; alloc_addr = 5'd0;
    rd(5'd0, 5'd0, 5'd0, 5'd0);
    push(0, 1, {1'b1, 32'h0}, "zero_no_bypass");
    cycle();
    idle();
    push(0, 0, {1'b1, 32'h0}, "zero_reads_0");
    push(0, -1, 33'h0, "zero_never_pending");
    push(1, 0, {1'b0, 32'hFFFF_FFFF}, "nozero_r0_stored");
    cycle();
    wr(2'b10, 5'd0, 32'h0, 5'd0, 32'h0);
    cycle();
    idle();

    // Bypass versus no bypass
    wr(2'b01, 5'd9, 32'h0000_0099, 5'd0, 32'h0);
    cycle();
    wr(2'b01, 5'd9, 32'hCAFE_F00D, 5'd0, 32'h0); rd(5'd0, 5'd9, 5'd0, 5'd0);
    push(0, 1, {1'b1, 32'hCAFE_F00D}, "bypass_same_cycle");
    push(1, 1, {1'b1, 32'h0000_0099}, "nobypass_old_value");
    cycle();
    idle();
    push(1, 1, {1'b1, 32'hCAFE_F00D}, "nobypass_next_cycle");
    cycle();

    // Scoreboard
    alloc_en = 1'b1; alloc_addr = 5'd12; rd(5'd12, 5'd12, 5'd0, 5'd0);
    cycle();
    idle();
    push(0, 0, {1'b0, 32'h0}, "r12_pending");
    push(0, -1, 33'h1, "pend_any_set");
    cycle();
    alloc_en = 1'b1; alloc_addr = 5'd12;
    cycle();
    idle(); wr(2'b10, 5'd0, 32'h0, 5'd12, 32'h0000_0005);
    push(0, 0, {1'b1, 32'h0000_0005}, "writeback_bypass_ready");
    push(1, 0, {1'b0, 32'h0}, "writeback_nobypass_pending");
    cycle();
    idle();
    push(0, 0, {1'b1, 32'h0000_0005}, "r12_cleared");
    push(0, -1, 33'h0, "pend_any_clear");
    cycle();
    wr(2'b01, 5'd12, 32'h0000_0006, 5'd0, 32'h0); alloc_en = 1'b1; alloc_addr = 5'd12;
    cycle();
    idle(); rd(5'd0, 5'd12, 5'd0, 5'd12);
    push(0, 1, {1'b0, 32'h0000_0006}, "alloc_beats_write");
    cycle();
    wr(2'b01, 5'd12, 32'h0000_0007, 5'd0, 32'h0);
    cycle();
    idle();

    // Multi-port independent reads
    wr(2'b11, 5'd1, 32'h1, 5'd2, 32'h2);
    cycle();
    wr(2'b11, 5'd3, 32'h3, 5'd4, 32'h4);
    cycle();
    idle(); rd(5'd1, 5'd2, 5'd3, 5'd4);
    for (int p = 0; p < 4; p++) push(0, p, {1'b1, 32'(p + 1)}, "multiport");
    cycle();

    // Random traffic checked against the model
    for (int i = 0; i < 60; i++) begin
      clr        = ($urandom_range(0, 29) != 0);
      wr_en      = 2'($urandom_range(0, 3));
      wr_addr    = 10'($urandom_range(0, 1023));
      wr_data    = {$urandom, $urandom};
      rd_addr    = 20'($urandom);
      alloc_en   = 1'($urandom_range(0, 1));
      alloc_addr = 5'($urandom_range(0, 31));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
